// File: rtl/usb_stuff_nrzi_if.sv
// Serial TX bus between the parallel-to-serial shifter and the stuff/NRZI encoder.
// tx_oe exists only when USB_TX_OE_EN is defined.
interface usb_stuff_nrzi_if;
  logic clk12;
  logic serial_in;
  logic tx_active;
  logic bit_stuff_en;
  logic dplus_out;
  logic dminus_out;
  logic eop_done;
`ifdef USB_TX_OE_EN
  logic tx_oe;
`endif

  modport master (
    output clk12,
    output serial_in,
    output tx_active,
    input  bit_stuff_en,
    input  dplus_out,
    input  dminus_out,
`ifdef USB_TX_OE_EN
    input  tx_oe,
`endif
    input  eop_done
  );

  modport slave (
    input  clk12,
    input  serial_in,
    input  tx_active,
    output bit_stuff_en,
    output dplus_out,
    output dminus_out,
`ifdef USB_TX_OE_EN
    output tx_oe,
`endif
    output eop_done
  );
endinterface

// File: rtl/usb_stuff_nrzi.sv
// USB full-speed TX bit stuffer and NRZI line encoder with SE0/J end-of-packet.
// Optional output-enable tracking is built when USB_TX_OE_EN is defined.
module usb_stuff_nrzi #(
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  usb_stuff_nrzi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, EOP_SE0, EOP_J} state_t;

  localparam logic [2:0] STUFF_LIM = 3'(STUFF_LIMIT);
  localparam logic [1:0] EOP_LIM   = 2'(EOP_SE0_BITS);

  state_t     r_state, w_state_next;
  logic [2:0] r_ones_cnt, w_ones_next;
  logic [1:0] r_eop_cnt, w_eop_next;
  logic       r_dp, w_dp_next;
  logic       r_dm, w_dm_next;
  logic       r_eop_done, w_eop_done_next;
  logic       r_oe, w_oe_next;
  logic       w_stuff_due;

  assign w_stuff_due = (r_state == DATA) && (r_ones_cnt == STUFF_LIM);

  always_comb begin
    w_state_next    = r_state;
    w_ones_next     = r_ones_cnt;
    w_eop_next      = r_eop_cnt;
    w_dp_next       = r_dp;
    w_dm_next       = r_dm;
    w_oe_next       = r_oe;
    w_eop_done_next = 1'b0;
    if (bus.clk12) begin
      case (r_state)
        IDLE: begin
          w_dp_next   = 1'b1;
          w_dm_next   = 1'b0;
          w_ones_next = 3'd0;
          if (bus.tx_active) begin
            w_state_next = DATA;
            w_oe_next    = 1'b1;
            // First bit is encoded relative to the J idle level.
            if (bus.serial_in) begin
              w_ones_next = 3'd1;
            end else begin
              w_dp_next = 1'b0;
              w_dm_next = 1'b1;
            end
          end
        end
        DATA: begin
          if (w_stuff_due) begin
            w_dp_next   = ~r_dp;
            w_dm_next   = ~r_dm;
            w_ones_next = 3'd0;
          end else if (!bus.tx_active) begin
            w_state_next = EOP_SE0;
            w_dp_next    = 1'b0;
            w_dm_next    = 1'b0;
            w_eop_next   = 2'd1;
          end else if (bus.serial_in) begin
            w_ones_next = r_ones_cnt + 3'd1;
          end else begin
            w_dp_next   = ~r_dp;
            w_dm_next   = ~r_dm;
            w_ones_next = 3'd0;
          end
        end
        EOP_SE0: begin
          w_dp_next = 1'b0;
          w_dm_next = 1'b0;
          if (r_eop_cnt == EOP_LIM) begin
            w_state_next = EOP_J;
            w_dp_next    = 1'b1;
          end else begin
            w_eop_next = r_eop_cnt + 2'd1;
          end
        end
        EOP_J: begin
          w_state_next    = IDLE;
          w_dp_next       = 1'b1;
          w_dm_next       = 1'b0;
          w_eop_next      = 2'd0;
          w_ones_next     = 3'd0;
          w_eop_done_next = 1'b1;
          w_oe_next       = 1'b0;
        end
        default: begin
          w_state_next = IDLE;
          w_dp_next    = 1'b1;
          w_dm_next    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ones_cnt <= 3'd0;
      r_eop_cnt  <= 2'd0;
      r_dp       <= 1'b1;
      r_dm       <= 1'b0;
      r_eop_done <= 1'b0;
      r_oe       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ones_cnt <= w_ones_next;
      r_eop_cnt  <= w_eop_next;
      r_dp       <= w_dp_next;
      r_dm       <= w_dm_next;
      r_eop_done <= w_eop_done_next;
      r_oe       <= w_oe_next;
    end
  end

  assign bus.bit_stuff_en = w_stuff_due;
  assign bus.dplus_out    = r_dp;
  assign bus.dminus_out   = r_dm;
  assign bus.eop_done     = r_eop_done;
`ifdef USB_TX_OE_EN
  assign bus.tx_oe        = r_oe;
`else
  logic w_oe_unused;
  assign w_oe_unused = r_oe;
`endif
endmodule
